// File: rtl/mcp3008_pkg.sv
// mcp3008_pkg
//   Shared types and helpers for the MCP3008 responder.
//   - state_t   : responder frame state
//   - cfg_t     : {SGL, D2, D1, D0} configuration captured from the master
//   - diff_code : single-ended or pseudo-differential code selection with
//                 saturation of negative differences to zero
package mcp3008_pkg;

  localparam int ADC_BITS = 10;
  localparam int NUM_CH   = 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    CFG,
    NULL_BIT,
    MSB,
    LSB,
    ZERO
  } state_t;

  typedef struct packed {
    logic       sgl;
    logic [2:0] sel;
  } cfg_t;

  function automatic logic [ADC_BITS-1:0] diff_code(
    input cfg_t                         cfg,
    input logic [NUM_CH*ADC_BITS-1:0]   ch_data
  );
    logic [ADC_BITS-1:0] even_v;
    logic [ADC_BITS-1:0] odd_v;
    logic [ADC_BITS-1:0] pos_v;
    logic [ADC_BITS-1:0] neg_v;
    logic [ADC_BITS:0]   diff_v;
    logic [ADC_BITS-1:0] result;
    even_v = ch_data[int'({cfg.sel[2:1], 1'b0}) * ADC_BITS +: ADC_BITS];
    odd_v  = ch_data[int'({cfg.sel[2:1], 1'b1}) * ADC_BITS +: ADC_BITS];
    // D0 picks which channel of the pair is the positive input.
    pos_v  = cfg.sel[0] ? odd_v  : even_v;
    neg_v  = cfg.sel[0] ? even_v : odd_v;
    // One extra bit so a borrow shows up as the sign of the difference.
    diff_v = {1'b0, pos_v} - {1'b0, neg_v};
    if (cfg.sgl) begin
      result = ch_data[int'(cfg.sel) * ADC_BITS +: ADC_BITS];
    end else if (diff_v[ADC_BITS]) begin
      result = '0;
    end else begin
      result = diff_v[ADC_BITS-1:0];
    end
    return result;
  endfunction

endpackage

// File: rtl/mcp3008_responder_if.sv
// mcp3008_responder_if
//   SPI pins between the motor-control master and the ADC responder.
//   sclk/cs_n/din : master -> responder
//   dout/dout_oe  : responder -> master (dout_oe=0 models high-Z)
interface mcp3008_responder_if;
  logic sclk;
  logic cs_n;
  logic din;
  logic dout;
  logic dout_oe;

  modport master (output sclk, output cs_n, output din, input dout, input dout_oe);
  modport slave  (input sclk, input cs_n, input din, output dout, output dout_oe);
endinterface

// File: rtl/mcp3008_responder_spi_edge_sync.sv
// mcp3008_responder_spi_edge_sync
//   Brings the asynchronous SPI pins into the clk domain.
//   Ports: clk, rst_n, sclk/cs_n/din (raw pins)
//          sclk_rise/sclk_fall : one-clk edge pulses of synced sclk
//          cs_n_s/din_s        : synced levels, aligned with the sclk edges
//          ready               : high once the chains hold post-reset samples
module mcp3008_responder_spi_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sclk,
  input  logic cs_n,
  input  logic din,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_n_s,
  output logic din_s,
  output logic ready
);

  logic [SYNC_STAGES-1:0] sclk_q;
  logic [SYNC_STAGES-1:0] cs_q;
  logic [SYNC_STAGES-1:0] din_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   sclk_d;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its neighbour's pre-edge value and the chain really delays.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= '0;
      cs_q   <= '1;
      din_q  <= '0;
      fill_q <= '0;
      sclk_d <= 1'b0;
    end else begin
      sclk_q[0] <= sclk;
      cs_q[0]   <= cs_n;
      din_q[0]  <= din;
      fill_q[0] <= 1'b1;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_q[i] <= sclk_q[i-1];
        cs_q[i]   <= cs_q[i-1];
        din_q[i]  <= din_q[i-1];
        fill_q[i] <= fill_q[i-1];
      end
      sclk_d <= sclk_q[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_d;
  assign sclk_fall = ~sclk_q[SYNC_STAGES-1] & sclk_d;
  assign cs_n_s    = cs_q[SYNC_STAGES-1];
  assign din_s     = din_q[SYNC_STAGES-1];
  // The reset value of cs_q reads as "deselected"; ready tells the frame
  // logic when that value has been replaced by a real pin sample.
  assign ready     = fill_q[SYNC_STAGES-1];

endmodule

// File: rtl/mcp3008_responder.sv
// mcp3008_responder
//   Cycle-accurate MCP3008 emulator: decodes start/SGL/D2..D0 from the
//   master, samples the selected channel on the D0 rise and shifts the code
//   out MSB-first, then LSB-first, then zeros.
//   Ports: clk, rst_n
//          spi        : SPI pins (slave modport)
//          ch_data    : channel i at [ADC_BITS*i +: ADC_BITS]
//          conv_valid : one-clk pulse when a conversion is latched
//          conv_cfg   : {SGL,D2,D1,D0} of the latched conversion
//          conv_code  : code served for the current frame
//          frame_err  : one-clk pulse when cs_n rises before B0 is sent
module mcp3008_responder
  import mcp3008_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADC_BITS    = mcp3008_pkg::ADC_BITS,
  parameter int NUM_CH      = mcp3008_pkg::NUM_CH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  mcp3008_responder_if.slave         spi,
  input  logic [NUM_CH*ADC_BITS-1:0] ch_data,
  output logic                       conv_valid,
  output logic [3:0]                 conv_cfg,
  output logic [ADC_BITS-1:0]        conv_code,
  output logic                       frame_err
);

  localparam int CNT_W = $clog2(ADC_BITS);

  logic sclk_rise, sclk_fall, cs_n_s, din_s, sync_ready;

  mcp3008_responder_spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_spi_edge_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (spi.sclk),
    .cs_n      (spi.cs_n),
    .din       (spi.din),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_n_s    (cs_n_s),
    .din_s     (din_s),
    .ready     (sync_ready)
  );

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [2:0]            cfg_q, cfg_d;
  logic                  armed_q, armed_d;
  logic                  dout_q, dout_d;
  logic                  oe_q, oe_d;
  logic                  conv_valid_d, frame_err_d;
  logic [3:0]            conv_cfg_d;
  logic [ADC_BITS-1:0]   conv_code_d;
  cfg_t                  new_cfg;
  logic [CNT_W-1:0]      msb_idx, lsb_idx;

  assign new_cfg = cfg_t'({cfg_q, din_s});
  assign msb_idx = CNT_W'(ADC_BITS-1) - bit_cnt_q;
  assign lsb_idx = bit_cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      cfg_q      <= '0;
      armed_q    <= 1'b0;
      dout_q     <= 1'b0;
      oe_q       <= 1'b0;
      conv_valid <= 1'b0;
      conv_cfg   <= '0;
      conv_code  <= '0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      cfg_q      <= cfg_d;
      armed_q    <= armed_d;
      dout_q     <= dout_d;
      oe_q       <= oe_d;
      conv_valid <= conv_valid_d;
      conv_cfg   <= conv_cfg_d;
      conv_code  <= conv_code_d;
      frame_err  <= frame_err_d;
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path
    // through the case statement can leave a latch behind.
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    cfg_d        = cfg_q;
    dout_d       = dout_q;
    oe_d         = oe_q;
    conv_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    conv_cfg_d   = conv_cfg;
    conv_code_d  = conv_code;
    // After reset a frame only starts once cs_n has really been seen high.
    armed_d      = armed_q | (cs_n_s & sync_ready);

    if (cs_n_s) begin
      // Deselect beats any sclk edge arriving in the same clk.
      state_d     = IDLE;
      bit_cnt_d   = '0;
      cfg_d       = '0;
      dout_d      = 1'b0;
      oe_d        = 1'b0;
      frame_err_d = state_q inside {CFG, NULL_BIT, MSB};
    end else begin
      unique case (state_q)
        IDLE: begin
          if (armed_q) begin
            state_d = WAIT_START;
            oe_d    = 1'b1;
            dout_d  = 1'b0;
          end
        end
        WAIT_START: begin
          // Leading zeros before the start bit are ignored.
          if (sclk_rise && din_s) begin
            state_d   = CFG;
            bit_cnt_d = '0;
          end
        end
        CFG: begin
          if (sclk_rise) begin
            cfg_d     = new_cfg[2:0];
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(3)) begin
              // D0 rise: sample/hold the selected input for the whole frame.
              conv_valid_d = 1'b1;
              conv_cfg_d   = new_cfg;
              conv_code_d  = diff_code(new_cfg, ch_data);
              state_d      = NULL_BIT;
              bit_cnt_d    = '0;
            end
          end
        end
        NULL_BIT: begin
          if (sclk_fall) begin
            dout_d  = 1'b0;
            state_d = MSB;
          end
        end
        MSB: begin
          if (sclk_fall) begin
            dout_d    = conv_code[msb_idx];
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(ADC_BITS-1)) begin
              state_d   = LSB;
              bit_cnt_d = '0;
            end
          end
        end
        LSB: begin
          // B0 was the last MSB-first bit, so the echo starts at B1.
          if (sclk_fall) begin
            dout_d    = conv_code[lsb_idx];
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(ADC_BITS-2)) begin
              state_d   = ZERO;
              bit_cnt_d = '0;
            end
          end
        end
        ZERO: begin
          if (sclk_fall) dout_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign spi.dout    = dout_q;
  assign spi.dout_oe = oe_q;

endmodule

// File: doc/mcp3008_responder.md
Name: mcp3008_responder

Overview:
- Cycle-accurate MCP3008 (8-ch, 10-bit SPI ADC) emulator: the responder end of the bit-banged ADC SPI link the motor-control logic drives on AD_CLK/CS/DIN/DOUT.
- Oversamples the SPI pins in the system clock domain and serves 10-bit codes from a packed channel-value input.
- Used in simulation and hardware-in-the-loop, in place of the physical ADC, to exercise throttle/battery paths.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the input synchronisers on sclk/cs_n/din
ADC_BITS, 10, conversion width
NUM_CH, 8, number of channels

Ports:
clk  input  1  system clock (50 MHz)
rst_n  input  1  asynchronous active-low reset
sclk  input  1  SPI clock from master (asynchronous to clk)
cs_n  input  1  chip select, active low
din  input  1  master-to-responder serial data
ch_data  input  NUM_CH*ADC_BITS  channel i value at [10i+9:10i]
dout  output  1  responder-to-master serial data
dout_oe  output  1  1 while dout is driven (0 models high-Z)
conv_valid  output  1  one-clk pulse when a conversion is latched
conv_cfg  output  4  {SGL,D2,D1,D0} of the latched conversion
conv_code  output  ADC_BITS  code latched for the current frame
frame_err  output  1  one-clk pulse when cs_n rises before B0 has been shifted out

Behaviour:
- Reset: dout=0, dout_oe=0, conv_valid=0, conv_cfg=0, conv_code=0, frame_err=0, state IDLE, synchronisers cleared to sclk=0, cs_n=1, din=0.
- Inputs pass through SYNC_STAGES flops. Rise/fall events come from comparing the last two synced sclk samples.
- Required: clk at least 8x sclk. Every dout update occurs within SYNC_STAGES+2 clk of the sclk falling edge.
- Sampling: din is sampled on sclk rise. dout changes only on sclk fall.
- States:
  - IDLE: dout_oe=0. cs_n low -> WAIT_START.
  - WAIT_START: dout_oe=1, dout=0. On each rise, din=0 is ignored (leading zeros allowed); din=1 -> CFG with bit count 0.
  - CFG: 4 rises capture SGL, D2, D1, D0 MSB-first. On the D0 rise, compute the code from ch_data (sample/hold) and load it. Pulse conv_valid the same clk, update conv_cfg/conv_code, then -> NULL.
  - NULL: on the next fall dout=0 (null bit) -> MSB.
  - MSB: next 10 falls drive B9..B0 -> LSB.
  - LSB: next 9 falls drive B1..B9 (B0 is not repeated) -> ZERO.
  - ZERO: dout=0 on every further fall.
- Code selection:
  - SGL=1: code = ch[{D2,D1,D0}].
  - SGL=0: pair p={D2,D1}, even = ch[2p], odd = ch[2p+1]. D0=0 gives even-odd; D0=1 gives odd-even. Negative results saturate to 0. Subtract at ADC_BITS+1 width.
- cs_n high (synced) in any state: -> IDLE within 1 clk, dout_oe=0, dout=0, counters cleared.
  - frame_err pulses if leaving CFG, NULL or MSB.
  - No pulse from WAIT_START, LSB or ZERO.
- Simultaneous synced cs_n rise and sclk edge: cs_n wins, the edge is ignored.
- ch_data changes after the D0 rise do not affect the frame in progress.
- rst_n asserted mid-frame: immediate return to reset values. Frame resumes only after cs_n goes high then low again; while cs_n stays low after reset release, stay in IDLE.

Decomposition:
- mcp3008_pkg:
  - state enum (IDLE, WAIT_START, CFG, NULL_BIT, MSB, LSB, ZERO)
  - ADC_BITS, NUM_CH
  - cfg_t packed struct {sgl, sel[2:0]}
  - function diff_code(cfg_t, ch_data) returning the saturated code
- Sub-module spi_edge_sync: parameterised synchroniser plus rise/fall detect for sclk. It also synchronises cs_n and din at the same depth.

Test Plan:
- Single-ended ch5=10'h2A5, master sends 0,0,1,1,1,0,1 -> conv_valid, conv_cfg=4'b1101, dout after null = 1010100101, then LSB-first 010010101, then 0s.
- Differential cfg 0010 (CH2-CH3), ch2=600, ch3=200 -> code 400 (0110010000). Cfg 0011 -> code 0 (saturated).
- ch_data switched from 100 to 900 two sclk periods after the D0 rise -> remaining bits still encode 100.
- cs_n raised after 4 of 10 MSB bits -> frame_err one clk, dout_oe=0 within SYNC_STAGES+2 clk, then a new frame on ch0=1023 returns 1111111111.
- rst_n pulsed low mid-MSB with cs_n held low -> outputs at reset values, no response to further sclk until cs_n toggles high/low.
- Back-to-back frames, all 8 single-ended channels at sclk=clk/1351 -> 8 conv_valid pulses with matching conv_cfg/conv_code and no frame_err.
